mem_rr_arbiter: RTL

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_rr_arbiter_pkg.sv | 28 ++
 rtl/mem_rr_arbiter_picker.sv | 38 +++
 rtl/mem_rr_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared memory-controller constants, the arbiter state type and small
// index helpers used by the round-robin arbiter.
package mem_rr_arbiter_pkg;

  localparam int MEM_DATA_WIDTH_DEF    = 16;
  localparam int MEM_ADDR_WIDTH_DEF    = 8;
  localparam int MEM_NUM_CONSUMERS_DEF = 4;
  localparam int MEM_COUNT_WIDTH       = 32;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } mem_arb_state_t;

  // Width of a consumer index; a single consumer still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Successor of a consumer index, wrapping at n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_picker.sv
// Round-robin search: first asserted request at or after ptr, wrapping
// around the request vector.
module rr_priority_picker
  import mem_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] index
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   pos;

  // Rotate so bit 0 of req_rot is the consumer at ptr.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  // Lowest rotated position wins; map it back to an absolute index.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        index = IDX_WIDTH'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel between
// NUM_CONSUMERS requesters, one transaction in flight at a time.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = MEM_DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int NUM_CONSUMERS = MEM_NUM_CONSUMERS_DEF,
  parameter int WRITE_ENABLE  = 1,
  localparam int ID_W         = id_width(NUM_CONSUMERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
  input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
  output logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]              consumer_write_valid,
  input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_write_address,
  input  logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]              consumer_write_ready,
  output logic                                  mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0]              mem_read_address,
  input  logic                                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0]                 mem_read_data,
  output logic                                  mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0]              mem_write_address,
  output logic [DATA_WIDTH-1:0]                 mem_write_data,
  input  logic                                  mem_write_ready,
  output logic                                  grant_valid,
  output logic [ID_W-1:0]                       grant_id,
  output logic [MEM_COUNT_WIDTH-1:0]            completed_count
);

  localparam bit WR_EN = (WRITE_ENABLE != 0);

  mem_arb_state_t state_q, state_d;

  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]            grant_id_q, grant_id_d;
  logic                       grant_valid_q, grant_valid_d;
  logic                       mrv_q, mrv_d;
  logic [ADDRESS_WIDTH-1:0]   mra_q, mra_d;
  logic                       mwv_q, mwv_d;
  logic [ADDRESS_WIDTH-1:0]   mwa_q, mwa_d;
  logic [DATA_WIDTH-1:0]      mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0]   crr_q, crr_d;
  logic [NUM_CONSUMERS-1:0]   cwr_q, cwr_d;
  logic [DATA_WIDTH-1:0]      rd_data_q [NUM_CONSUMERS];
  logic [DATA_WIDTH-1:0]      rd_data_d [NUM_CONSUMERS];
  logic [MEM_COUNT_WIDTH-1:0] count_q, count_d;

  logic [ADDRESS_WIDTH-1:0]   rd_addr_arr [NUM_CONSUMERS];
  logic [ADDRESS_WIDTH-1:0]   wr_addr_arr [NUM_CONSUMERS];
  logic [DATA_WIDTH-1:0]      wr_data_arr [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0]   req_vec;
  logic                       pick_found;
  logic [ID_W-1:0]            pick_idx;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_unpack
    assign rd_addr_arr[g] = consumer_read_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wr_addr_arr[g] = consumer_write_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wr_data_arr[g] = consumer_write_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign consumer_read_data[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
  end

  // With writes disabled, write requests never reach the picker.
  assign req_vec = WR_EN ? (consumer_read_valid | consumer_write_valid)
                         : consumer_read_valid;

  rr_priority_picker #(
    .NUM_REQ  (NUM_CONSUMERS),
    .IDX_WIDTH(ID_W)
  ) u_picker (
    .req  (req_vec),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .index(pick_idx)
  );

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    mrv_d         = mrv_q;
    mra_d         = mra_q;
    mwv_d         = mwv_q;
    mwa_d         = mwa_q;
    mwd_d         = mwd_q;
    crr_d         = crr_q;
    cwr_d         = cwr_q;
    rd_data_d     = rd_data_q;
    count_d       = count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          // A consumer with both requests pending gets its read first.
          if (consumer_read_valid[pick_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = rd_addr_arr[pick_idx];
            state_d = READ_WAITING;
          end else if (WR_EN) begin
            mwv_d   = 1'b1;
            mwa_d   = wr_addr_arr[pick_idx];
            mwd_d   = wr_data_arr[pick_idx];
            state_d = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mrv_d                 = 1'b0;
          crr_d[grant_id_q]     = 1'b1;
          rd_data_d[grant_id_q] = mem_read_data;
          state_d               = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mwv_d             = 1'b0;
          cwr_d[grant_id_q] = 1'b1;
          state_d           = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_id_q]) begin
          crr_d[grant_id_q] = 1'b0;
          grant_valid_d     = 1'b0;
          rr_ptr_d          = ID_W'(rr_next(int'(grant_id_q), NUM_CONSUMERS));
          count_d           = count_q + 1'b1;
          state_d           = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant_id_q]) begin
          cwr_d[grant_id_q] = 1'b0;
          grant_valid_d     = 1'b0;
          rr_ptr_d          = ID_W'(rr_next(int'(grant_id_q), NUM_CONSUMERS));
          count_d           = count_q + 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      mrv_q         <= 1'b0;
      mra_q         <= '0;
      mwv_q         <= 1'b0;
      mwa_q         <= '0;
      mwd_q         <= '0;
      crr_q         <= '0;
      cwr_q         <= '0;
      count_q       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) rd_data_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      mrv_q         <= mrv_d;
      mra_q         <= mra_d;
      mwv_q         <= mwv_d;
      mwa_q         <= mwa_d;
      mwd_q         <= mwd_d;
      crr_q         <= crr_d;
      cwr_q         <= cwr_d;
      count_q       <= count_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = WR_EN & mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;
  assign consumer_read_ready  = crr_q;
  assign consumer_write_ready = WR_EN ? cwr_q : '0;
  assign grant_valid          = grant_valid_q;
  assign grant_id             = grant_id_q;
  assign completed_count      = count_q;

endmodule
